vga_sync_gen: RTL and testbench
===============================

Name: vga_sync_gen

Overview:
- Consumes the divided pixel-rate pulse and generates VGA raster timing for the road-fighter display path: hsync, vsync, the active-video flag, pixel coordinates, and line/frame strobes.
- Runs on the fast system clock. Advances one pixel per cycle in which pix_en is high.
- Sits between the pixel-rate clock generation and the sprite/road renderer, which samples x, y and video_on.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, asserted level of hsync and vsync (0 = active-low)
- CW, 10, width of the x/y outputs; must satisfy 2^CW >= max(H_TOTAL, V_TOTAL)

Ports:
- clk  in  1  system clock; all state updates on posedge
- rst_n  in  1  asynchronous active-low reset
- pix_en  in  1  pixel advance enable, one clk cycle wide, from the divided pixel-rate pulse
- hsync  out  1  horizontal sync, level set by SYNC_POL
- vsync  out  1  vertical sync, level set by SYNC_POL
- video_on  out  1  high while the current position is inside the active area
- x  out  CW  current column while video_on, else 0
- y  out  CW  current row while video_on, else 0
- line_start  out  1  one-clk pulse when h_count wraps to 0 (every line, including blanking lines)
- frame_start  out  1  one-clk pulse when (h_count, v_count) becomes (0, 0)

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Internal counters:
  - h_count runs 0..H_TOTAL-1; v_count runs 0..V_TOTAL-1.
  - On a clk edge with pix_en=1, h_count increments. At H_TOTAL-1 it wraps to 0, and v_count then increments, wrapping from V_TOTAL-1 to 0.
  - With pix_en=0, all counters and level outputs hold, and both strobes are 0.
- Reset (asynchronous, while rst_n=0):
  - h_count=H_TOTAL-1, v_count=V_TOTAL-1 (last pixel of the frame).
  - hsync=vsync=~SYNC_POL, video_on=0, x=y=0, line_start=frame_start=0.
  - The first pix_en after release moves the position to (0,0) and fires both strobes.
- All outputs are registered and updated on the same edge as the counters, so outputs always describe the post-edge position. Compute them from the next-state counter values; no extra pipeline stage.
- hsync = SYNC_POL when h_count is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] (656..751 by default), else ~SYNC_POL.
- vsync = SYNC_POL when v_count is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] (490..491), else ~SYNC_POL.
- video_on = (h_count < H_ACTIVE) and (v_count < V_ACTIVE).
- Strobes:
  - line_start is high for exactly the one clk cycle after an edge that wrapped h_count.
  - frame_start is additionally high on that same cycle when v_count also wrapped to 0. At the frame wrap both strobes are high together.
- pix_en held high continuously is legal; the block then advances every clk cycle.
- Back-to-back strobes are possible only in that case, with H_TOTAL=1.
- Reset asserted mid-frame: immediate return to the reset state, with no partial sync pulse held. Restart follows the rule above.

Decomposition:
- Package vga_timing_pkg holds the default timing constants (640x480@60), the derived H_TOTAL/V_TOTAL, and the sync start/end column and row constants.
- One natural sub-module: wrap_counter (parameter MAX; inputs clk, rst_n, en; outputs count, wrap). Instantiated twice: horizontal with en=pix_en, vertical with en=pix_en & h_wrap.
- Output decode stays in vga_sync_gen.

Test Plan:
- Reset then release, pix_en low: hsync=vsync=1, video_on=0, x=y=0, no strobes. First pix_en: next cycle frame_start=line_start=1, video_on=1, x=0, y=0.
- pix_en every 4th clk: line_start period exactly 3200 clk; hsync low for 384 clk, starting 2624 clk after line_start; frame_start period 1,680,000 clk.
- pix_en tied high, full frame: video_on high for exactly 307200 cycles per frame; vsync low exactly for lines 490–491; x at column 639 then video_on=0 at 640.
- Random pix_en gaps: outputs frozen across gaps; after 800 enables from line_start, line_start fires again and y increments by 1.
- rst_n pulsed low mid-frame (e.g. during hsync at line 100): outputs return to reset values immediately; restart yields frame_start on the first subsequent pix_en.
- Small config (H 4/1/1/1, V 3/1/1/1, SYNC_POL=1): exhaustive check of a 7x6 raster against a reference model over 3 frames, including the simultaneous line/frame wrap.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// ============================================================================
// Module   : vga_timing_pkg
// Brief    : Default 640x480@60 raster timing constants and a window helper.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package vga_timing_pkg;

    localparam int c_H_ACTIVE = 640;
    localparam int c_H_FP     = 16;
    localparam int c_H_SYNC   = 96;
    localparam int c_H_BP     = 48;
    localparam int c_V_ACTIVE = 480;
    localparam int c_V_FP     = 10;
    localparam int c_V_SYNC   = 2;
    localparam int c_V_BP     = 33;

    localparam int c_H_TOTAL  = c_H_ACTIVE + c_H_FP + c_H_SYNC + c_H_BP;
    localparam int c_V_TOTAL  = c_V_ACTIVE + c_V_FP + c_V_SYNC + c_V_BP;

    localparam int c_HS_START = c_H_ACTIVE + c_H_FP;
    localparam int c_HS_END   = c_HS_START + c_H_SYNC - 1;
    localparam int c_VS_START = c_V_ACTIVE + c_V_FP;
    localparam int c_VS_END   = c_VS_START + c_V_SYNC - 1;

    function automatic logic in_window(input int unsigned v,
                                       input int unsigned lo,
                                       input int unsigned hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

`default_nettype wire

// File: rtl/vga_sync_gen_wrap_counter.sv
// ============================================================================
// Module   : wrap_counter
// Brief    : Enabled 0..MAX counter with a same-cycle wrap indication.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wrap_counter #(
    parameter int MAX = 799,
    parameter int W   = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         wrap
);

    logic [W-1:0] count_q;

    // Wrap is asserted on the cycle whose edge takes the count back to zero.
    assign wrap  = en && (count_q == W'(MAX));
    assign count = count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= W'(MAX);
        end else if (en) begin
            count_q <= wrap ? '0 : count_q + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/vga_sync_gen.sv
// ============================================================================
// Module   : vga_sync_gen
// Brief    : VGA raster timing: syncs, active flag, coordinates and strobes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE = c_H_ACTIVE,
    parameter int   H_FP     = c_H_FP,
    parameter int   H_SYNC   = c_H_SYNC,
    parameter int   H_BP     = c_H_BP,
    parameter int   V_ACTIVE = c_V_ACTIVE,
    parameter int   V_FP     = c_V_FP,
    parameter int   V_SYNC   = c_V_SYNC,
    parameter int   V_BP     = c_V_BP,
    parameter logic SYNC_POL = 1'b0,
    parameter int   CW       = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pix_en,
    output logic          hsync,
    output logic          vsync,
    output logic          video_on,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          line_start,
    output logic          frame_start
);

    localparam int c_H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int c_HS_LO = H_ACTIVE + H_FP;
    localparam int c_HS_HI = c_HS_LO + H_SYNC - 1;
    localparam int c_VS_LO = V_ACTIVE + V_FP;
    localparam int c_VS_HI = c_VS_LO + V_SYNC - 1;

    logic [CW-1:0] w_h_count, w_v_count, w_h_next, w_v_next;
    logic          w_h_wrap, w_v_wrap, w_v_en;

    assign w_v_en = pix_en & w_h_wrap;

    wrap_counter #(.MAX(c_H_TOT - 1), .W(CW)) u_h_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (pix_en),
        .count (w_h_count),
        .wrap  (w_h_wrap)
    );

    wrap_counter #(.MAX(c_V_TOT - 1), .W(CW)) u_v_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (w_v_en),
        .count (w_v_count),
        .wrap  (w_v_wrap)
    );

    // Outputs describe the post-edge position, so decode the next counter values.
    assign w_h_next = w_h_wrap ? '0 : (pix_en ? w_h_count + 1'b1 : w_h_count);
    assign w_v_next = w_v_wrap ? '0 : (w_v_en ? w_v_count + 1'b1 : w_v_count);

    logic          hsync_d, vsync_d, video_on_d, line_start_d, frame_start_d;
    logic [CW-1:0] x_d, y_d;
    logic          hsync_q, vsync_q, video_on_q, line_start_q, frame_start_q;
    logic [CW-1:0] x_q, y_q;

    always_comb begin
        video_on_d    = (w_h_next < CW'(H_ACTIVE)) && (w_v_next < CW'(V_ACTIVE));
        hsync_d       = in_window(32'(w_h_next), c_HS_LO, c_HS_HI) ? SYNC_POL : ~SYNC_POL;
        vsync_d       = in_window(32'(w_v_next), c_VS_LO, c_VS_HI) ? SYNC_POL : ~SYNC_POL;
        x_d           = video_on_d ? w_h_next : '0;
        y_d           = video_on_d ? w_v_next : '0;
        line_start_d  = w_v_en;
        frame_start_d = w_v_wrap;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            video_on_q    <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            video_on_q    <= video_on_d;
            x_q           <= x_d;
            y_q           <= y_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign video_on    = video_on_q;
    assign x           = x_q;
    assign y           = y_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_sync_gen.sv
// ============================================================================
// Module   : tb_vga_sync_gen
// Brief    : Self-checking bench for vga_sync_gen (default and 7x6 raster).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_sync_gen;

    localparam int c_TOT_D = 800 * 525;
    localparam int c_TOT_S = 7 * 6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pe_d = 1'b0;
    logic       pe_s = 1'b0;
    logic       hs_d, vs_d, vo_d, ls_d, fs_d;
    logic [9:0] x_d, y_d;
    logic       hs_s, vs_s, vo_s, ls_s, fs_s;
    logic [3:0] x_s, y_s;

    always #5 clk = ~clk;

    vga_sync_gen u_dut_d (
        .clk(clk), .rst_n(rst_n), .pix_en(pe_d),
        .hsync(hs_d), .vsync(vs_d), .video_on(vo_d), .x(x_d), .y(y_d),
        .line_start(ls_d), .frame_start(fs_d)
    );

    vga_sync_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SYNC_POL(1'b1), .CW(4)
    ) u_dut_s (
        .clk(clk), .rst_n(rst_n), .pix_en(pe_s),
        .hsync(hs_s), .vsync(vs_s), .video_on(vo_s), .x(x_s), .y(y_s),
        .line_start(ls_s), .frame_start(fs_s)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    // Reference: position is a linear pixel index n within the frame.
    typedef struct {int hs; int vs; int vo; int x; int y; int ls; int fs;} exp_t;

    function automatic exp_t model(input int n, input bit en,
                                   input int ha, input int hfp, input int hsw, input int hbp,
                                   input int va, input int vfp, input int vsw, input int pol);
        exp_t m;
        int   ht = ha + hfp + hsw + hbp;
        int   h  = n % ht;
        int   v  = n / ht;
        m.hs = (h >= ha + hfp && h < ha + hfp + hsw) ? pol : 1 - pol;
        m.vs = (v >= va + vfp && v < va + vfp + vsw) ? pol : 1 - pol;
        m.vo = (h < ha && v < va) ? 1 : 0;
        m.x  = m.vo ? h : 0;
        m.y  = m.vo ? v : 0;
        m.ls = (en && h == 0) ? 1 : 0;
        m.fs = (en && n == 0) ? 1 : 0;
        return m;
    endfunction

    int n_d, n_s;
    bit en_d, en_s;
    int cyc = 0;
    bit meas_on = 0, prev_hs = 1, tracking = 0;
    int last_ls = -1, hs_run = 0;

    task automatic check_outputs();
        exp_t e;
        e = model(n_d, en_d, 640, 16, 96, 48, 480, 10, 2, 0);
        chk("d_hsync", 32'(hs_d), e.hs);  chk("d_vsync", 32'(vs_d), e.vs);
        chk("d_video_on", 32'(vo_d), e.vo);
        chk("d_x", 32'(x_d), e.x);        chk("d_y", 32'(y_d), e.y);
        chk("d_line_start", 32'(ls_d), e.ls);
        chk("d_frame_start", 32'(fs_d), e.fs);
        e = model(n_s, en_s, 4, 1, 1, 1, 3, 1, 1, 1);
        chk("s_hsync", 32'(hs_s), e.hs);  chk("s_vsync", 32'(vs_s), e.vs);
        chk("s_video_on", 32'(vo_s), e.vo);
        chk("s_x", 32'(x_s), e.x);        chk("s_y", 32'(y_s), e.y);
        chk("s_line_start", 32'(ls_s), e.ls);
        chk("s_frame_start", 32'(fs_s), e.fs);
    endtask

    task automatic measure();
        if (meas_on) begin
            if (ls_d) begin
                if (last_ls >= 0) chk("ls_period", cyc - last_ls, 3200);
                last_ls = cyc;
            end
            if (prev_hs && !hs_d) begin
                if (last_ls >= 0) chk("hs_offset", cyc - last_ls, 2624);
                tracking = 1;
                hs_run   = 0;
            end
            if (tracking) begin
                if (!hs_d) hs_run++;
                else begin
                    chk("hs_width", hs_run, 384);
                    tracking = 0;
                end
            end
            prev_hs = hs_d;
        end
    endtask

    task automatic step(input bit pd, input bit ps);
        check_outputs();
        measure();
        pe_d = pd;
        pe_s = ps;
        if (pd) n_d = (n_d + 1) % c_TOT_D;
        if (ps) n_s = (n_s + 1) % c_TOT_S;
        en_d = pd;
        en_s = ps;
        @(negedge clk);
        cyc++;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_d_hsync"}, 32'(hs_d), 1);  chk({tag, "_d_vsync"}, 32'(vs_d), 1);
        chk({tag, "_d_video_on"}, 32'(vo_d), 0);
        chk({tag, "_d_xy"}, 32'({x_d, y_d}), 0);
        chk({tag, "_d_strobes"}, 32'({ls_d, fs_d}), 0);
        chk({tag, "_s_syncs"}, 32'({hs_s, vs_s}), 0);
        chk({tag, "_s_video_on"}, 32'(vo_s), 0);
    endtask

    task automatic model_reset();
        n_d = c_TOT_D - 1; n_s = c_TOT_S - 1;
        en_d = 0; en_s = 0;
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_values("rst");
        rst_n = 1'b1;
        repeat (3) step(1'b0, 1'b0);
        check_reset_values("idle");

        // pix_en every 4th clk on the default raster
        meas_on = 1;
        step(1'b1, 1'b1);
        chk("first_frame_start", 32'(fs_d), 1);
        chk("first_line_start", 32'(ls_d), 1);
        chk("first_video_on", 32'(vo_d), 1);
        chk("first_xy", 32'({x_d, y_d}), 0);
        chk("first_s_strobes", 32'({ls_s, fs_s}), 3);
        for (int i = 1; i < 6600; i++) step(i % 4 == 0, bit'($urandom_range(0, 1)));
        meas_on = 0;

        for (int i = 0; i < 8000; i++)
            step($urandom_range(0, 2) == 0, bit'($urandom_range(0, 1)));

        for (int i = 0; i < 3000; i++) step(1'b1, 1'b1);

        // Reset in the middle of an hsync pulse
        for (int k = 0; k < 2000 && hs_d !== 1'b0; k++) step(1'b1, bit'($urandom_range(0, 1)));
        chk("hs_wait", 32'(hs_d), 0);
        #2;
        rst_n = 1'b0;
        pe_d  = 1'b0;
        pe_s  = 1'b0;
        #1;
        check_reset_values("midrst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) step(1'b0, 1'b0);
        step(1'b1, 1'b1);
        chk("restart_frame_start", 32'(fs_d), 1);
        chk("restart_s_frame_start", 32'(fs_s), 1);
        for (int i = 0; i < 300; i++) step(1'b1, bit'($urandom_range(0, 1)));
        check_outputs();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
